stack_ctrl: RTL and testbench

Stack controller that sits between the CPU datapath and the `memstack` word memory and owns the stack protocol on the memory's port.
- Accepts push, pop and replace-top requests through a ready/valid-style handshake.
- Maintains the stack pointer and full/empty state.
- Drives address, write-enable and write data into `memstack`, and captures its asynchronous read data into a registered pop result.
- Overflow and underflow attempts are reported through sticky error flags and never corrupt memory or pointer state.

---
 rtl/stack_ctrl_if.sv | 37 +++
 rtl/stack_ctrl.sv | 107 ++++++++++
 tb/tb_stack_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_if.sv
// Stack controller bus: CPU request/response side plus memstack port.
// master = CPU/memory side, slave = controller.
interface stack_ctrl_if #(
    parameter int WIDTH  = 16,
    parameter int NWORDS = 1024
);
    localparam int AW = $clog2(NWORDS);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             req_ready;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
    logic             clr_err;
    logic [AW-1:0]    mem_a;
    logic             mem_we;
    logic [WIDTH-1:0] mem_din;
    logic [WIDTH-1:0] mem_dout;

    modport master (
        output push, pop, push_data, clr_err, mem_dout,
        input  req_ready, pop_data, pop_valid, count, full, empty,
        input  overflow, underflow, mem_a, mem_we, mem_din
    );

    modport slave (
        input  push, pop, push_data, clr_err, mem_dout,
        output req_ready, pop_data, pop_valid, count, full, empty,
        output overflow, underflow, mem_a, mem_we, mem_din
    );
endinterface

// File: rtl/stack_ctrl.sv
// Stack controller: owns push/pop/replace protocol on a memstack port.
// One operation per two cycles; errors are sticky and side-effect free.
module stack_ctrl #(
    parameter int WIDTH  = 16,
    parameter int NWORDS = 1024
) (
    input logic         clk,
    input logic         reset,
    stack_ctrl_if.slave bus
);
    localparam int AW = $clog2(NWORDS);
    localparam logic [AW:0] FULLV = (AW+1)'(NWORDS);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, SWAP} state_t;

    state_t           state, state_n;
    logic [AW:0]      count;
    logic [AW:0]      top;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] pdata;
    logic             pvalid;
    logic             ovf, unf;
    logic             idle, req, full, empty;
    logic             set_ovf, set_unf;
    logic             we;

    assign idle  = (state == IDLE);
    assign req   = idle && (bus.push || bus.pop);
    assign full  = (count == FULLV);
    assign empty = (count == '0);
    assign top   = count - ONE;

    always_comb begin
        state_n  = state;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        we       = 1'b0;
        bus.mem_a = top[AW-1:0];
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (bus.push && full)
                        set_ovf = 1'b1;
                    else if (bus.pop && empty)
                        set_unf = 1'b1;
                    else if (bus.push && bus.pop)
                        state_n = SWAP;
                    else if (bus.push)
                        state_n = WRITE;
                    else
                        state_n = READ;
                end
            end
            WRITE: begin
                we        = 1'b1;
                bus.mem_a = count[AW-1:0];
                state_n   = IDLE;
            end
            READ: state_n = IDLE;
            SWAP: begin
                // old top is read through mem_dout before this write lands
                we      = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            hold   <= '0;
            pdata  <= '0;
            pvalid <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            state  <= state_n;
            pvalid <= 1'b0;
            if (req)
                hold <= bus.push_data;
            if (state == WRITE)
                count <= count + ONE;
            if (state == READ)
                count <= count - ONE;
            if (state == READ || state == SWAP) begin
                pdata  <= bus.mem_dout;
                pvalid <= 1'b1;
            end
            ovf <= set_ovf || (ovf && !bus.clr_err);
            unf <= set_unf || (unf && !bus.clr_err);
        end
    end

    assign bus.mem_we    = we && reset;
    assign bus.mem_din   = hold;
    assign bus.req_ready = idle;
    assign bus.pop_data  = pdata;
    assign bus.pop_valid = pvalid;
    assign bus.count     = count;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.overflow  = ovf;
    assign bus.underflow = unf;
endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl against a queue-based stack model.
// A small array stands in for memstack.
module tb_stack_ctrl;
    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    stack_ctrl_if #(.WIDTH(W), .NWORDS(N)) sif ();

    stack_ctrl #(.WIDTH(W), .NWORDS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [N];
    int wr_cnt = 0;

    always_comb sif.mem_dout = mem[sif.mem_a];

    always @(posedge clk) begin
        if (sif.mem_we) begin
            mem[sif.mem_a] <= sif.mem_din;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int ncheck = 0;
    int nerr = 0;

    logic [W-1:0] stk [$];
    logic [W-1:0] exp_pd = '0;
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;
    int exp_wr = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ncheck++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle();
        int sz = stk.size();
        chk("ready", sif.req_ready, 1);
        chk("count", sif.count, sz);
        chk("empty", sif.empty, sz == 0);
        chk("full", sif.full, sz == N);
        chk("ovf", sif.overflow, m_ovf);
        chk("unf", sif.underflow, m_unf);
        chk("pop_data", sif.pop_data, exp_pd);
        chk("wr_cnt", wr_cnt, exp_wr);
        chk("we_idle", sif.mem_we, 0);
        chk("a_idle", sif.mem_a, (sz - 1) & (N - 1));
        for (int i = 0; i < sz; i++)
            chk($sformatf("mem%0d", i), mem[i], stk[i]);
    endtask

    task automatic do_op(input logic p, input logic q,
                         input logic [W-1:0] d, input logic c);
        int sz = stk.size();
        logic so, su;
        int kind;
        chk("ready_pre", sif.req_ready, 1);
        sif.push = p;
        sif.pop = q;
        sif.push_data = d;
        sif.clr_err = c;
        so = p && (sz == N);
        su = !so && q && (sz == 0);
        kind = 0;
        if ((p || q) && !so && !su)
            kind = (p && q) ? 3 : (p ? 1 : 2);
        @(posedge clk);
        #1;
        sif.push = 1'b0;
        sif.pop = 1'b0;
        sif.clr_err = 1'b0;
        m_ovf = so || (m_ovf && !c);
        m_unf = su || (m_unf && !c);
        chk("pv_first", sif.pop_valid, 0);
        if (kind != 0) begin
            chk("busy", sif.req_ready, 0);
            chk("we_busy", sif.mem_we, kind == 1 || kind == 3);
            chk("a_busy", sif.mem_a,
                (kind == 1 ? sz : sz - 1) & (N - 1));
            if (kind != 2)
                chk("din", sif.mem_din, d);
            if (kind == 1) begin
                stk.push_back(d);
                exp_wr++;
            end else if (kind == 2) begin
                exp_pd = stk.pop_back();
            end else begin
                exp_pd = stk[sz-1];
                stk[sz-1] = d;
                exp_wr++;
            end
            @(posedge clk);
            #1;
            chk("pv_done", sif.pop_valid, kind >= 2);
        end
        chk_idle();
    endtask

    task automatic reset_mid_write();
        logic [W-1:0] old;
        old = mem[0];
        chk("rst_pre_empty", sif.empty, 1);
        sif.push = 1'b1;
        sif.push_data = ~old;
        @(posedge clk);
        #1;
        sif.push = 1'b0;
        chk("rst_busy", sif.req_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst_we_gated", sif.mem_we, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        exp_pd = '0;
        chk("rst_mem0", mem[0], old);
        chk("rst_pv", sif.pop_valid, 0);
        chk("rst_din", sif.mem_din, 0);
        chk_idle();
    endtask

    initial begin
        sif.push = 1'b0;
        sif.pop = 1'b0;
        sif.push_data = '0;
        sif.clr_err = 1'b0;
        for (int i = 0; i < N; i++)
            mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("r_count", sif.count, 0);
        chk("r_empty", sif.empty, 1);
        chk("r_full", sif.full, 0);
        chk("r_ready", sif.req_ready, 1);
        chk("r_pv", sif.pop_valid, 0);
        chk("r_pd", sif.pop_data, 0);
        chk("r_ovf", sif.overflow, 0);
        chk("r_unf", sif.underflow, 0);
        chk("r_we", sif.mem_we, 0);
        chk("r_a", sif.mem_a, N - 1);
        chk("r_din", sif.mem_din, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        do_op(1, 0, 16'h1111, 0);
        do_op(1, 0, 16'h2222, 0);
        do_op(1, 0, 16'h3333, 0);
        chk("three_count", sif.count, 3);
        do_op(0, 1, 16'h0, 0);
        chk("pop1", sif.pop_data, 16'h3333);
        do_op(0, 1, 16'h0, 0);
        chk("pop2", sif.pop_data, 16'h2222);
        do_op(0, 1, 16'h0, 0);
        chk("pop3", sif.pop_data, 16'h1111);

        do_op(1, 0, 16'hAAAA, 0);
        do_op(1, 1, 16'hBBBB, 0);
        chk("swap_pd", sif.pop_data, 16'hAAAA);
        chk("swap_mem0", mem[0], 16'hBBBB);
        do_op(0, 1, 16'h0, 0);

        do_op(0, 1, 16'h0, 0);
        chk("unf_set", sif.underflow, 1);
        do_op(0, 0, 16'h0, 1);
        chk("unf_clr", sif.underflow, 0);
        do_op(1, 1, 16'h5555, 1);
        chk("unf_setwins", sif.underflow, 1);
        do_op(0, 0, 16'h0, 1);

        for (int i = 0; i < N; i++)
            do_op(1, 0, W'(16'h4000 + i), 0);
        chk("full", sif.full, 1);
        do_op(1, 0, 16'hDEAD, 0);
        chk("ovf_set", sif.overflow, 1);
        do_op(1, 1, 16'hBEEF, 0);
        do_op(0, 0, 16'h0, 1);
        for (int i = 0; i < N; i++)
            do_op(0, 1, 16'h0, 0);

        do_op(1, 0, 16'h7777, 0);
        do_op(0, 1, 16'h0, 0);
        reset_mid_write();

        for (int i = 0; i < 400; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  W'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
        $finish;
    end
endmodule
